bcd_down_counter: RTL and testbench
===================================

// Module: bcd_down_counter
// PURPOSE
//  Multi-digit BCD countdown counter. It is the down-counting counterpart of the team's
//  0-9 BCD up counter. Loads a preset, then decrements one count per enabled clock.
//  A borrow ripples across decimal digits. Flags terminal count at zero.
//  Used as a countdown timer / event-budget counter feeding 7-segment decode logic.
// PARAMETERS
//  DIGITS       2  number of BCD digits (1..4); count width = 4*DIGITS
//  AUTO_RELOAD  0  1: on reaching zero, reload the saved preset and keep running
//                  0: stop at zero in DONE
// PORTS
//  clk    in   1         rising-edge clock, single clock domain
//  rst    in   1         synchronous reset, active-low (sampled on posedge clk)
//  load   in   1         load din into count and preset register
//  din    in   4*DIGITS  preset value, BCD, digit 0 in [3:0]
//  start  in   1         begin or restart countdown
//  en     in   1         count enable; 0 pauses the count in RUN
//  q      out  4*DIGITS  current count, BCD
//  busy   out  1         high while in RUN
//  done   out  1         high while in DONE
//  tc     out  1         one-cycle pulse in the cycle q becomes 0 by decrement
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): q=0, preset=0, state=IDLE, busy=0, done=0, tc=0.
//  - Priority, evaluated each posedge: rst > load > start > en.
//  - Digit sanitising on load: any din digit >9 is stored as 9, per digit, in both q and preset.
//  - Decrement: digit0-=1. A digit equal to 0 becomes 9 and borrows from the next digit.
//    Never produces non-BCD digits.
//  - FSM states: IDLE, RUN, DONE.
//    - Any state: load -> IDLE. q<=din', preset<=din'. tc=0.
//    - IDLE: start & q!=0 -> RUN. start & q==0 -> DONE. Otherwise hold.
//    - RUN, en=0: hold q.
//    - RUN, en=1, q>1: decrement.
//    - RUN, en=1, q==1: q<=0 and tc=1 next cycle.
//      If AUTO_RELOAD=0 -> DONE.
//      If AUTO_RELOAD=1, stay RUN. q shows 0 for that one cycle, and the next enabled
//      count reloads preset (no decrement on that count).
//      If preset==0 with AUTO_RELOAD=1, go to DONE instead.
//    - RUN, start: q<=preset, stay RUN (restart). No tc.
//    - DONE: hold q=0. start -> q<=preset. Next state is RUN if preset!=0, else stay DONE.
//  - Outputs are registered; q, busy, done and tc change only on posedge clk.
//    Latency load->q is 1 cycle. start->first decrement: the first decrement occurs
//    on the cycle after entering RUN, with en=1.
//  - tc is high for exactly one cycle per zero-crossing. It is never asserted on load of 0.
//  - Mid-operation reset forces the reset values on the next edge, regardless of
//    load, start or en.
//  - Full-scale value: all digits 9 (99 for DIGITS=2). There is no up-count and no
//    wrap below 0 other than AUTO_RELOAD.
// TESTING  (DIGITS=2 unless noted)
//  1. rst=0 for 2 clk, then load din=8'h23, start, en=1
//     -> q: 23,22,21,20,19,...,01,00. tc=1 with q=00. done=1, busy=0. q holds 00.
//  2. load 8'h10, start, en=1
//     -> q: 10, 09 (borrow 1->0, 0->9), then 08.
//     Toggle en=0 for 3 cycles -> q holds 08.
//  3. load din=8'hA5 -> q=8'h95 (upper digit clamped). load 8'h00 and start -> DONE,
//     tc stays 0.
//  4. AUTO_RELOAD=1: load 8'h03, start, en=1
//     -> q: 03,02,01,00(tc=1),03,02,... and busy stays 1 throughout.
//  5. In RUN at q=8'h15: assert rst=0 together with load=1
//     -> next edge q=00, IDLE, all flags 0. The load is ignored.
//  6. DONE, then start -> q=preset (8'h23), busy=1. Assert start mid-count at q=8'h17
//     -> q=8'h23 next cycle.

Source files
------------

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
//   Multi-digit BCD countdown counter. A preset is loaded (each digit clamped
//   to 9 if it is not a valid BCD digit), then the count decrements once per
//   enabled clock while running, with a borrow rippling across decimal digits.
//   A one-cycle terminal-count pulse marks the decrement that reaches zero.
//   With AUTO_RELOAD=1 the counter shows 0 for one count and then reloads the
//   saved preset and keeps running; with AUTO_RELOAD=0 it stops in DONE.
//
// Parameters
//   DIGITS       number of BCD digits (1..4), count width = 4*DIGITS
//   AUTO_RELOAD  1: reload preset after reaching zero, 0: stop at zero
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    synchronous reset, active-low
//   i_load   load i_din into count and preset (sanitised per digit)
//   i_din    preset value, BCD, digit 0 in [3:0]
//   i_start  begin or restart the countdown
//   i_en     count enable; low pauses the count while running
//   o_q      current count, BCD
//   o_busy   high while running
//   o_done   high while stopped at zero
//   o_tc     one-cycle pulse in the cycle o_q becomes 0 by decrement
// -----------------------------------------------------------------------------
module bcd_down_counter #(
    parameter int DIGITS      = 2,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_din,
    input  logic                  i_start,
    input  logic                  i_en,
    output logic [4*DIGITS-1:0]   o_q,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_tc
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_preset;
    logic           r_busy;
    logic           r_done;
    logic           r_tc;

    logic [W-1:0]   w_din_clean;
    logic [W-1:0]   w_q_dec;
    logic           w_q_zero;
    logic           w_q_one;
    logic           w_preset_zero;

    // Clamp every digit above 9 to 9 so the count never holds non-BCD digits.
    function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                r[4*d +: 4] = 4'd9;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    // Subtract one: a digit at 0 becomes 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (borrow) begin
                if (v[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    assign w_din_clean   = bcd_sanitize(i_din);
    assign w_q_dec       = bcd_decrement(r_q);
    assign w_q_zero      = (r_q == ZERO);
    assign w_q_one       = (r_q == ONE);
    assign w_preset_zero = (r_preset == ZERO);

    // Countdown FSM with registered count and flags; priority rst > load > start > en.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= ST_IDLE;
            r_q      <= ZERO;
            r_preset <= ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_load) begin
                r_q      <= w_din_clean;
                r_preset <= w_din_clean;
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (w_q_zero) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (i_start) begin
                            r_q <= r_preset;
                        end else if (i_en) begin
                            if (w_q_zero) begin
                                // Only reachable after an auto-reload zero count:
                                // this count restores the preset instead of decrementing.
                                r_q <= r_preset;
                            end else if (w_q_one) begin
                                r_q  <= ZERO;
                                r_tc <= 1'b1;
                                if ((AUTO_RELOAD == 0) || w_preset_zero) begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_q <= w_q_dec;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (i_start) begin
                            r_q <= r_preset;
                            if (!w_preset_zero) begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_q    = r_q;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_tc   = r_tc;

endmodule

// File: tb/tb_bcd_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_counter
//   Scoreboard bench for bcd_down_counter (DIGITS=2). Two instances share the
//   stimulus: u_dut0 with AUTO_RELOAD=0 and u_dut1 with AUTO_RELOAD=1. Each
//   stimulus cycle pushes the expected post-edge outputs for one instance; a
//   monitor pops and compares on the following falling edge.
// -----------------------------------------------------------------------------
module tb_bcd_down_counter;

    logic       clk = 1'b0;
    logic       rst, load, start, en;
    logic [7:0] din;

    logic [7:0] q0, q1;
    logic       busy0, done0, tc0, busy1, done1, tc1;

    typedef struct {
        bit         which;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       tc;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_din(din),
        .i_start(start), .i_en(en),
        .o_q(q0), .o_busy(busy0), .o_done(done0), .o_tc(tc0)
    );

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_din(din),
        .i_start(start), .i_en(en),
        .o_q(q1), .o_busy(busy1), .o_done(done1), .o_tc(tc1)
    );

    function automatic logic [7:0] bcd8(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic ld, input logic [7:0] d,
                        input logic st, input logic e, input bit which,
                        input logic [7:0] eq, input logic eb, input logic ed,
                        input logic et, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; din = d; start = st; en = e;
        @(posedge clk);
        x.which = which; x.q = eq; x.busy = eb; x.done = ed; x.tc = et; x.nm = nm;
        sb.push_back(x);
    endtask

    // Monitor: compare the oldest expectation against the selected instance.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       x;
            logic [7:0] aq;
            logic       ab, ad, at;
            x  = sb.pop_front();
            aq = x.which ? q1    : q0;
            ab = x.which ? busy1 : busy0;
            ad = x.which ? done1 : done0;
            at = x.which ? tc1   : tc0;
            checks++;
            if (aq !== x.q || ab !== x.busy || ad !== x.done || at !== x.tc) begin
                failures++;
                $display("FAIL %s: got q=%h busy=%b done=%b tc=%b, want q=%h busy=%b done=%b tc=%b",
                         x.nm, aq, ab, ad, at, x.q, x.busy, x.done, x.tc);
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0; load = 1'b0; din = 8'h00; start = 1'b0; en = 1'b0;

        // 1: reset, load 23, count down to 00 with tc, then hold in DONE
        step(0,0,8'h00,0,0, 0, 8'h00,0,0,0, "t1_rst_a");
        step(0,0,8'h00,0,0, 0, 8'h00,0,0,0, "t1_rst_b");
        step(1,1,8'h23,0,0, 0, 8'h23,0,0,0, "t1_load23");
        step(1,0,8'h00,1,0, 0, 8'h23,1,0,0, "t1_start");
        for (int n = 22; n >= 1; n--)
            step(1,0,8'h00,0,1, 0, bcd8(n),1,0,0, $sformatf("t1_cnt%0d", n));
        step(1,0,8'h00,0,1, 0, 8'h00,0,1,1, "t1_zero_tc");
        step(1,0,8'h00,0,1, 0, 8'h00,0,1,0, "t1_hold_done");

        // 2: borrow 10 -> 09 -> 08, enable low pauses
        step(1,1,8'h10,0,0, 0, 8'h10,0,0,0, "t2_load10");
        step(1,0,8'h00,0,1, 0, 8'h10,0,0,0, "t2_idle_en_nocount");
        step(1,0,8'h00,1,0, 0, 8'h10,1,0,0, "t2_start");
        step(1,0,8'h00,0,1, 0, 8'h09,1,0,0, "t2_borrow09");
        step(1,0,8'h00,0,1, 0, 8'h08,1,0,0, "t2_dec08");
        for (int k = 0; k < 3; k++)
            step(1,0,8'h00,0,0, 0, 8'h08,1,0,0, $sformatf("t2_pause%0d", k));

        // 3: digit clamping, load of zero never pulses tc
        step(1,1,8'hA5,0,0, 0, 8'h95,0,0,0, "t3_clampA5");
        step(1,1,8'h3C,0,0, 0, 8'h39,0,0,0, "t3_clamp3C");
        step(1,0,8'h00,1,0, 0, 8'h39,1,0,0, "t3_start39");
        step(1,0,8'h00,0,1, 0, 8'h38,1,0,0, "t3_dec38");
        step(1,1,8'h00,0,0, 0, 8'h00,0,0,0, "t3_load00");
        step(1,0,8'h00,1,0, 0, 8'h00,0,1,0, "t3_start0_done");
        step(1,0,8'h00,0,1, 0, 8'h00,0,1,0, "t3_done_notc");
        step(1,0,8'h00,1,0, 0, 8'h00,0,1,0, "t3_done_start_p0");

        // 5: reset together with load mid-run wins
        step(1,1,8'h16,0,0, 0, 8'h16,0,0,0, "t5_load16");
        step(1,0,8'h00,1,0, 0, 8'h16,1,0,0, "t5_start");
        step(1,0,8'h00,0,1, 0, 8'h15,1,0,0, "t5_dec15");
        step(0,1,8'h42,1,1, 0, 8'h00,0,0,0, "t5_rst_load");
        step(1,0,8'h00,0,1, 0, 8'h00,0,0,0, "t5_idle_after");
        step(1,0,8'h00,1,0, 0, 8'h00,0,1,0, "t5_start_p0_done");

        // 6: start from DONE reloads preset; restart mid-count
        step(1,1,8'h23,0,0, 0, 8'h23,0,0,0, "t6_load23");
        step(1,0,8'h00,1,0, 0, 8'h23,1,0,0, "t6_start");
        for (int n = 22; n >= 1; n--)
            step(1,0,8'h00,0,1, 0, bcd8(n),1,0,0, $sformatf("t6_cnt%0d", n));
        step(1,0,8'h00,0,1, 0, 8'h00,0,1,1, "t6_zero_tc");
        step(1,0,8'h00,1,0, 0, 8'h23,1,0,0, "t6_done_start");
        for (int n = 22; n >= 17; n--)
            step(1,0,8'h00,0,1, 0, bcd8(n),1,0,0, $sformatf("t6_run%0d", n));
        step(1,0,8'h00,1,1, 0, 8'h23,1,0,0, "t6_restart");
        step(1,0,8'h00,0,1, 0, 8'h22,1,0,0, "t6_after_restart");

        // 4: AUTO_RELOAD instance
        step(0,0,8'h00,0,0, 1, 8'h00,0,0,0, "t4_rst");
        step(1,1,8'h03,0,0, 1, 8'h03,0,0,0, "t4_load03");
        step(1,0,8'h00,1,0, 1, 8'h03,1,0,0, "t4_start");
        step(1,0,8'h00,0,1, 1, 8'h02,1,0,0, "t4_02");
        step(1,0,8'h00,0,1, 1, 8'h01,1,0,0, "t4_01");
        step(1,0,8'h00,0,1, 1, 8'h00,1,0,1, "t4_00_tc");
        step(1,0,8'h00,0,1, 1, 8'h03,1,0,0, "t4_reload03");
        step(1,0,8'h00,0,1, 1, 8'h02,1,0,0, "t4_02b");
        step(1,0,8'h00,0,1, 1, 8'h01,1,0,0, "t4_01b");
        step(1,0,8'h00,0,1, 1, 8'h00,1,0,1, "t4_00_tc_b");
        step(1,0,8'h00,0,0, 1, 8'h00,1,0,0, "t4_pause_at0");
        step(1,0,8'h00,0,1, 1, 8'h03,1,0,0, "t4_reload_after_pause");
        step(1,0,8'h00,0,1, 1, 8'h02,1,0,0, "t4_02c");
        step(1,0,8'h00,1,1, 1, 8'h03,1,0,0, "t4_restart");

        // Drain the scoreboard within a bounded number of cycles.
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
